// File: rtl/dvp_tx.sv
// DVP camera-bus transmitter: serialises RGB565 pixels into vsync/href/8-bit frames
// with programmable horizontal and vertical blanking.
`timescale 1ns/1ps
module dvp_tx #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int H_BLANK  = 16,
  parameter int VS_LINES = 2,
  parameter int V_BP     = 4,
  parameter int V_FP     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  output logic        pix_ready,
  output logic        cmos_vsync,
  output logic        cmos_href,
  output logic [7:0]  cmos_db,
  output logic        frame_done,
  output logic        underflow,
  input  logic        clr_underflow
);

  localparam int L    = 2 * H_ACTIVE + H_BLANK;
  localparam int HW   = $clog2(L);
  localparam int VM01 = (VS_LINES > V_BP) ? VS_LINES : V_BP;
  localparam int VM23 = (V_ACTIVE > V_FP) ? V_ACTIVE : V_FP;
  localparam int VMAX = (VM01 > VM23) ? VM01 : VM23;
  localparam int VW   = (VMAX > 1) ? $clog2(VMAX) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(L - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(2 * H_ACTIVE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_ACTIVE,
    ST_VFP
  } state_t;

  // Zero-line phases are skipped by never entering them.
  localparam state_t FIRST_ST = (VS_LINES > 0) ? ST_VSYNC :
                                (V_BP > 0)     ? ST_VBP   : ST_ACTIVE;
  localparam state_t POST_VS  = (V_BP > 0) ? ST_VBP : ST_ACTIVE;
  localparam state_t LAST_ST  = (V_FP > 0) ? ST_VFP : ST_ACTIVE;

  function automatic logic [VW-1:0] last_line(input state_t s);
    case (s)
      ST_VSYNC:  last_line = VW'(VS_LINES - 1);
      ST_VBP:    last_line = VW'(V_BP - 1);
      ST_ACTIVE: last_line = VW'(V_ACTIVE - 1);
      ST_VFP:    last_line = VW'(V_FP - 1);
      default:   last_line = '0;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [7:0]    lo_q, lo_d;
  logic          vsync_q, vsync_d;
  logic          href_q, href_d;
  logic [7:0]    db_q, db_d;
  logic          frame_done_q, frame_done_d;
  logic          underflow_q, underflow_d;
  logic          act_d, even_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      lo_q         <= '0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      db_q         <= '0;
      frame_done_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      lo_q         <= lo_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      db_q         <= db_d;
      frame_done_q <= frame_done_d;
      underflow_q  <= underflow_d;
    end
  end

  // state_q/hcnt_q/vcnt_q name the byte position currently on the bus; *_d is the next one.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    if (state_q == ST_IDLE) begin
      if (enable) begin
        state_d = FIRST_ST;
        hcnt_d  = '0;
        vcnt_d  = '0;
      end
    end else if (hcnt_q != H_LAST) begin
      hcnt_d = hcnt_q + 1'b1;
    end else begin
      hcnt_d = '0;
      if (vcnt_q != last_line(state_q)) begin
        vcnt_d = vcnt_q + 1'b1;
      end else begin
        vcnt_d = '0;
        case (state_q)
          ST_VSYNC:  state_d = POST_VS;
          ST_VBP:    state_d = ST_ACTIVE;
          ST_ACTIVE: state_d = (V_FP > 0) ? ST_VFP : (enable ? FIRST_ST : ST_IDLE);
          ST_VFP:    state_d = enable ? FIRST_ST : ST_IDLE;
          default:   state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    act_d        = (state_d == ST_ACTIVE) && (hcnt_d < H_ACT);
    even_d       = act_d && !hcnt_d[0];
    vsync_d      = (state_d == ST_VSYNC);
    href_d       = act_d;
    lo_d         = lo_q;
    db_d         = 8'h00;
    if (even_d) begin
      db_d = pix_valid ? pix_data[15:8] : 8'h00;
      lo_d = pix_valid ? pix_data[7:0]  : 8'h00;
    end else if (act_d) begin
      db_d = lo_q;
    end
    frame_done_d = (state_d == LAST_ST) && (hcnt_d == H_LAST) &&
                   (vcnt_d == last_line(LAST_ST));
    // A fresh underflow takes priority over a same-cycle clear.
    if (even_d && !pix_valid) underflow_d = 1'b1;
    else if (clr_underflow)   underflow_d = 1'b0;
    else                      underflow_d = underflow_q;
  end

  assign pix_ready  = even_d;
  assign cmos_vsync = vsync_q;
  assign cmos_href  = href_q;
  assign cmos_db    = db_q;
  assign frame_done = frame_done_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_dvp_tx.sv
// Scoreboard bench for dvp_tx: a position-based frame model predicts every output cycle,
// a separate monitor pops and compares after each clock edge.
`timescale 1ns/1ps
module tb_dvp_tx;
  localparam int HA = 4, VA = 3, HB = 4, VS = 1, VBP = 1, VFP = 1;
  localparam int L = 2 * HA + HB;
  localparam int NL = VS + VBP + VA + VFP;
  localparam int FRAME = L * NL;

  logic        clk = 1'b0;
  logic        rst_n, enable, pix_valid, clr_underflow;
  logic [15:0] pix_data;
  logic        pix_ready, cmos_vsync, cmos_href, frame_done, underflow;
  logic [7:0]  cmos_db;

  always #5 clk = ~clk;

  dvp_tx #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
           .VS_LINES(VS), .V_BP(VBP), .V_FP(VFP)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(pix_ready), .cmos_vsync(cmos_vsync),
    .cmos_href(cmos_href), .cmos_db(cmos_db), .frame_done(frame_done),
    .underflow(underflow), .clr_underflow(clr_underflow)
  );

  typedef struct packed {
    logic       vs;
    logic       hr;
    logic [7:0] db;
    logic       fd;
    logic       uf;
  } out_t;

  out_t exp_q[$];
  int n_checks = 0, n_fail = 0;
  int m_frames = 0, dut_fd = 0, xfer_cnt = 0, rdy_cnt = 0, vs_period = -1;
  int mode = 0, drop_idx = -1;
  bit clr_on_drop = 0, clr_force = 0;

  function automatic bit in_active(input int p);
    int line, h;
    if (p < 0) return 1'b0;
    line = p / L;
    h = p % L;
    return (line >= VS + VBP) && (line < VS + VBP + VA) && (h < 2 * HA);
  endfunction

  function automatic bit even_active(input int p);
    return in_active(p) && ((p % L) % 2 == 0);
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // Predictor: sees the inputs of the current cycle and predicts the next output cycle.
  initial begin : predictor
    int m_pos, np;
    bit rdy, m_uf;
    logic [7:0] m_lo;
    out_t e;
    m_pos = -1; m_uf = 0; m_lo = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_pos = -1; m_uf = 0; m_lo = 8'h00;
        exp_q.delete();
        exp_q.push_back('0);
      end else begin
        np = (m_pos < 0 || m_pos == FRAME - 1) ? (enable ? 0 : -1) : m_pos + 1;
        rdy = even_active(np);
        n_checks++;
        if (pix_ready !== rdy) begin
          n_fail++;
          $display("FAIL pix_ready at pos %0d: got %0b want %0b", np, pix_ready, rdy);
        end
        e = '0;
        if (np >= 0) begin
          e.vs = (np / L) < VS;
          e.hr = in_active(np);
          if (rdy) begin
            e.db = pix_valid ? pix_data[15:8] : 8'h00;
            m_lo = pix_valid ? pix_data[7:0] : 8'h00;
          end else if (e.hr) begin
            e.db = m_lo;
          end
          e.fd = (np == FRAME - 1);
          if (e.fd) m_frames++;
        end
        if (rdy && !pix_valid) m_uf = 1;
        else if (clr_underflow) m_uf = 0;
        e.uf = m_uf;
        m_pos = np;
        exp_q.push_back(e);
      end
    end
  end

  initial begin : monitor
    out_t e, a;
    int cyc, last_rise;
    logic prev_vs;
    cyc = 0; last_rise = -1; prev_vs = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (rst_n) begin
          a = '{vs: cmos_vsync, hr: cmos_href, db: cmos_db, fd: frame_done, uf: underflow};
          n_checks++;
          if (a !== e) begin
            n_fail++;
            $display("FAIL outputs cyc %0d: got vs=%0b hr=%0b db=%02h fd=%0b uf=%0b want vs=%0b hr=%0b db=%02h fd=%0b uf=%0b",
                     cyc, a.vs, a.hr, a.db, a.fd, a.uf, e.vs, e.hr, e.db, e.fd, e.uf);
          end
          if (frame_done) dut_fd++;
          if (cmos_vsync && !prev_vs) begin
            if (last_rise >= 0) vs_period = cyc - last_rise;
            last_rise = cyc;
          end
          prev_vs = cmos_vsync;
        end else begin
          last_rise = -1;
          prev_vs = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    bit xfer, drop;
    @(negedge clk);
    xfer = pix_valid && pix_ready;
    if (xfer) xfer_cnt++;
    if (pix_ready) rdy_cnt++;
    @(posedge clk);
    #1;
    if (xfer) pix_data = (mode == 2) ? 16'($urandom) : pix_data + 16'd1;
    drop = (mode == 1) && pix_ready && (rdy_cnt == drop_idx);
    case (mode)
      2:       pix_valid = ($urandom_range(3) != 0);
      default: pix_valid = !drop;
    endcase
    clr_underflow = clr_force || (clr_on_drop && drop) || ((mode == 2) && ($urandom_range(9) == 0));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin : stimulus
    int f0, d0;
    rst_n = 1'b0; enable = 1'b0; pix_valid = 1'b0; clr_underflow = 1'b0;
    pix_data = 16'h1234;
    run(3);
    rst_n = 1'b1;
    run(20);
    chk("idle_no_ready", rdy_cnt, 0);
    chk("idle_no_frame_done", dut_fd, 0);

    // Single frame from a one-clock enable pulse, always-valid source.
    pix_valid = 1'b1; xfer_cnt = 0;
    enable = 1'b1; tick(); enable = 1'b0;
    run(90);
    chk("single_frame_pixels", xfer_cnt, 12);
    chk("single_frame_done", dut_fd, 1);
    chk("single_frame_data_next", pix_data, 16'h1234 + 12);
    chk("single_frame_no_underflow", underflow, 0);

    // Back-to-back frames with enable held high.
    xfer_cnt = 0; f0 = m_frames; d0 = dut_fd;
    enable = 1'b1; run(3 * FRAME); enable = 1'b0;
    run(90);
    chk("b2b_frames", dut_fd - d0, m_frames - f0);
    chk("b2b_pixels", xfer_cnt, 12 * (m_frames - f0));
    chk("b2b_period", vs_period, FRAME);

    // Missing second pixel of the first active line.
    mode = 1; drop_idx = 1; rdy_cnt = 0; xfer_cnt = 0;
    enable = 1'b1; tick(); enable = 1'b0;
    run(90);
    chk("underflow_pixels", xfer_cnt, 11);
    chk("underflow_sticky", underflow, 1);

    clr_force = 1'b1; tick(); clr_force = 1'b0;
    run(2);
    chk("underflow_cleared", underflow, 0);

    // Clear coinciding with a fresh underflow: set must win.
    clr_on_drop = 1'b1; rdy_cnt = 0; drop_idx = 5;
    enable = 1'b1; tick(); enable = 1'b0;
    run(90);
    chk("underflow_set_wins", underflow, 1);
    clr_on_drop = 1'b0; drop_idx = -1; mode = 0;
    clr_force = 1'b1; tick(); clr_force = 1'b0;
    run(2);

    // Enable dropped during an active line: frame still completes.
    xfer_cnt = 0; f0 = m_frames; d0 = dut_fd;
    enable = 1'b1; run(40); enable = 1'b0;
    run(90);
    chk("early_disable_frames", dut_fd - d0, 1);
    chk("early_disable_pixels", xfer_cnt, 12);

    // Randomised enable, pixel gaps, clears and data.
    mode = 2;
    for (int b = 0; b < 16; b++) begin
      enable = ($urandom_range(1) == 1);
      run(50);
    end
    enable = 1'b0; mode = 0;
    run(90);

    // Asynchronous reset in the middle of a frame.
    enable = 1'b1; tick(); enable = 1'b0;
    run(30);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {cmos_vsync, cmos_href, cmos_db, frame_done, underflow}, 0);
    run(2);
    rst_n = 1'b1;
    d0 = dut_fd; rdy_cnt = 0;
    run(20);
    chk("reset_back_to_idle_ready", rdy_cnt, 0);
    chk("reset_back_to_idle_fd", dut_fd - d0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
